// File: rtl/router_pkg.sv
//------------------------------------------------------------------------------
// Package     : router_pkg
// Description : Shared constants for the 1x3 router (FSM, register stage,
//               FIFOs): byte width, invalid destination code and the header
//               field positions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  localparam int DATA_W = 8;

  // Destination code 2'b11 has no FIFO behind it
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: payload length above, destination address below
  localparam int HDR_LEN_MSB  = DATA_W - 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  // True when a header addresses one of the three real output ports
  function automatic logic hdr_addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage : router_pkg

`default_nettype wire

// File: rtl/router_parity_acc.sv
//------------------------------------------------------------------------------
// Module      : router_parity_acc
// Description : Running XOR parity of header and payload bytes plus the
//               captured trailing parity byte; flags any difference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              clr,        // start of a new packet
  input  logic              hdr_en,
  input  logic [DATA_W-1:0] hdr_byte,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data_byte,
  input  logic              pkt_ld,
  input  logic [DATA_W-1:0] pkt_byte,
  output logic              mismatch
);

  logic [DATA_W-1:0] int_parity_q, int_parity_d;
  logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;

  // Accumulate the XOR of every byte that belongs to the packet body
  always_comb begin
    int_parity_d = int_parity_q;
    if (clr) begin
      int_parity_d = '0;
    end else begin
      if (hdr_en)  int_parity_d = int_parity_d ^ hdr_byte;
      if (data_en) int_parity_d = int_parity_d ^ data_byte;
    end
  end

  // Hold the parity byte sent by the source
  always_comb begin
    pkt_parity_d = pkt_parity_q;
    if (pkt_ld) pkt_parity_d = pkt_byte;
  end

  // Parity registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
    end
  end

  assign mismatch = (int_parity_q != pkt_parity_q);

endmodule : router_parity_acc

`default_nettype wire

// File: rtl/router_reg.sv
//------------------------------------------------------------------------------
// Module      : router_reg
// Description : Datapath register stage of the 1x3 router. Captures the
//               header, buffers one byte while the addressed FIFO is full,
//               drives the FIFO write data, and checks packet parity.
//               Optional macro ROUTER_REG_LEN_CHECK_EN adds a payload length
//               check to the error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module router_reg #(
  parameter int DATA_W = router_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  import router_pkg::*;

  logic [DATA_W-1:0] header_byte_q, header_byte_d;
  logic [DATA_W-1:0] full_byte_q,   full_byte_d;
  logic [DATA_W-1:0] dout_q,        dout_d;
  logic              parity_done_q, parity_done_d;
  logic              pd_dly_q;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;

  logic              ld_ok;        // load state, FIFO has room
  logic              ld_full;      // load state, FIFO full: park the byte
  logic              end_ld;       // parity byte written straight through
  logic              end_laf;      // parity byte drained from the buffer
  logic              data_acc;     // payload byte counts toward parity
  logic              pkt_ld;
  logic [DATA_W-1:0] pkt_byte;
  logic              par_mismatch;
  logic              pkt_error;

  assign ld_ok    = ld_state & ~fifo_full;
  assign ld_full  = ld_state & fifo_full;
  assign end_ld   = ld_ok & ~pkt_valid;
  assign end_laf  = laf_state & low_pkt_valid_q & ~parity_done_q;
  assign data_acc = ld_state & pkt_valid & ~full_state;
  assign pkt_ld   = end_ld | end_laf;
  assign pkt_byte = end_ld ? data_in : full_byte_q;

  // Capture the header unless it targets the non-existent port
  always_comb begin
    header_byte_d = header_byte_q;
    if (detect_add && pkt_valid &&
        hdr_addr_valid(data_in[HDR_ADDR_MSB:HDR_ADDR_LSB]))
      header_byte_d = data_in;
  end

  // FIFO write data, with a one-byte side buffer used while the FIFO is full
  always_comb begin
    dout_d      = dout_q;
    full_byte_d = full_byte_q;
    if (lfd_state)     dout_d      = header_byte_q;
    else if (ld_ok)    dout_d      = data_in;
    else if (ld_full)  full_byte_d = data_in;
    else if (laf_state) dout_d     = full_byte_q;
  end

  // Source dropped pkt_valid during load; the FSM's clear takes precedence
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (rst_int_reg)                low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid) low_pkt_valid_d = 1'b1;
  end

  // Parity byte captured, either directly or after draining the buffer
  always_comb begin
    parity_done_d = parity_done_q;
    if (detect_add)  parity_done_d = 1'b0;
    else if (pkt_ld) parity_done_d = 1'b1;
  end

  router_parity_acc #(
    .DATA_W (DATA_W)
  ) u_parity_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (detect_add),
    .hdr_en    (lfd_state),
    .hdr_byte  (header_byte_q),
    .data_en   (data_acc),
    .data_byte (data_in),
    .pkt_ld    (pkt_ld),
    .pkt_byte  (pkt_byte),
    .mismatch  (par_mismatch)
  );

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int LEN_W = DATA_W - HDR_LEN_LSB;

  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;

  // Count payload bytes accepted in the load state
  always_comb begin
    len_cnt_d = len_cnt_q;
    if (detect_add)    len_cnt_d = '0;
    else if (data_acc) len_cnt_d = len_cnt_q + LEN_W'(1);
  end

  // Payload counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) len_cnt_q <= '0;
    else      len_cnt_q <= len_cnt_d;
  end

  assign pkt_error = par_mismatch |
                     (len_cnt_q != header_byte_q[DATA_W-1:HDR_LEN_LSB]);
`else
  assign pkt_error = par_mismatch;
`endif

  // Judge the packet once, in the cycle after parity_done rises; hold it
  always_comb begin
    err_d = err_q;
    if (detect_add)                      err_d = 1'b0;
    else if (parity_done_q && !pd_dly_q) err_d = pkt_error;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      header_byte_q   <= '0;
      full_byte_q     <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      pd_dly_q        <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_byte_q   <= header_byte_d;
      full_byte_q     <= full_byte_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      pd_dly_q        <= parity_done_q;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule : router_reg

`default_nettype wire

// File: tb/tb_router_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_router_reg
// Description : Self-checking bench for router_reg. The bench plays the
//               router FSM, sends whole packets and predicts the byte stream,
//               parity_done, low_pkt_valid and err from packet contents.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_router_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         pkt_valid, fifo_full;
  logic [W-1:0] data_in;
  logic         detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [W-1:0] dout;
  logic         parity_done, low_pkt_valid, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_hdr;          // header the DUT should be holding
  logic [W-1:0] pay_q[$];         // payload of the packet being sent

  router_reg #(.DATA_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pkt_valid   = 1'b0;
    fifo_full   = 1'b0;
    data_in     = '0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  // Send one packet: header, pay_q, parity byte. use_par selects an explicit
  // parity byte instead of the correct one. full_pct: chance a byte meets a full FIFO.
  task automatic send_packet(input logic [W-1:0] hdr, input bit use_par,
                             input logic [W-1:0] par_in, input int full_pct);
    logic [W-1:0] par, pbyte, bval, prev;
    bit           exp_err, last, full;
    int           n;
    if (hdr[1:0] != 2'b11) exp_hdr = hdr;
    par = exp_hdr;
    foreach (pay_q[i]) par = par ^ pay_q[i];
    pbyte   = use_par ? par_in : par;
    exp_err = (pbyte != par);
`ifdef ROUTER_REG_LEN_CHECK_EN
    if (pay_q.size() != int'(exp_hdr[W-1:2])) exp_err = 1'b1;
`endif
    n = pay_q.size();

    idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    step();
    check("err_cleared", err, 1'b0);
    check("pd_cleared", parity_done, 1'b0);

    idle(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = W'($urandom);
    step();
    check("dout_hdr", dout, exp_hdr);
    prev = exp_hdr;

    for (int i = 0; i <= n; i++) begin
      last = (i == n);
      bval = last ? pbyte : pay_q[i];
      full = ($urandom_range(0, 99) < full_pct);
      idle(); ld_state = 1'b1; pkt_valid = !last; data_in = bval; fifo_full = full;
      step();
      if (!full) begin
        check("dout_ld", dout, bval);
      end else begin
        check("dout_hold", dout, prev);
        repeat ($urandom_range(0, 2)) begin
          idle(); full_state = 1'b1; fifo_full = 1'b1;
          step();
          check("dout_hold_full", dout, prev);
        end
        idle(); laf_state = 1'b1; data_in = W'($urandom);
        step();
        check("dout_laf", dout, bval);
      end
      prev = bval;
      if (!last) check("pd_early", parity_done, 1'b0);
    end

    check("parity_done", parity_done, 1'b1);
    check("low_pkt_valid", low_pkt_valid, 1'b1);
    check("err_not_yet", err, 1'b0);

    idle();
    step();
    check("err", err, exp_err);

    idle(); rst_int_reg = 1'b1;
    step();
    check("low_cleared", low_pkt_valid, 1'b0);
    check("err_held", err, exp_err);
    idle();
  endtask

  initial begin
    idle();
    exp_hdr = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_pd", parity_done, 1'b0);
    check("rst_low", low_pkt_valid, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Good packet, no back-pressure
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0C, 1'b0, 8'h00, 0);
    // Same packet, wrong parity byte
    send_packet(8'h0C, 1'b1, 8'h00, 0);
    // Every byte meets a full FIFO, including the parity byte
    pay_q = '{8'h55, 8'h66};
    send_packet(8'h08, 1'b0, 8'h00, 100);
    // Address 3 header: previous header (08) must be replayed
    pay_q = '{8'h77, 8'h99};
    send_packet(8'h0F, 1'b0, 8'h00, 0);
    // Length 3 header with only two payload bytes, correct parity
    pay_q = '{8'h11, 8'h22};
    send_packet(8'h0C, 1'b0, 8'h00, 0);

    // Reset in the middle of a packet, after parity_done and low_pkt_valid rose
    idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; step();
    idle(); lfd_state = 1'b1; pkt_valid = 1'b1; step();
    idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hA5; step();
    idle(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = 8'h3C; step();
    check("mid_dout", dout, 8'h3C);
    check("mid_pd", parity_done, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_pd", parity_done, 1'b0);
    check("arst_low", low_pkt_valid, 1'b0);
    check("arst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle();
    exp_hdr = '0;
    // Invalid address right after reset: cleared header is replayed
    pay_q = '{8'h01};
    send_packet(8'h07, 1'b0, 8'h00, 0);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      logic [W-1:0] hdr;
      int           len, npay;
      len  = $urandom_range(0, 5);
      hdr  = {6'(len), 2'($urandom_range(0, 3))};
      npay = len;
      if ($urandom_range(0, 4) == 0) npay = len + 1;
      pay_q.delete();
      for (int k = 0; k < npay; k++) pay_q.push_back(W'($urandom));
      send_packet(hdr, ($urandom_range(0, 3) == 0), W'($urandom), 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_router_reg

`default_nettype wire

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router, directly downstream of `router_fsm` and consuming its state strobes.
- Latches the packet header and buffers payload bytes while the destination FIFO is full.
- Drives the byte stream toward the FIFO write port.
- Accumulates running parity and compares it with the trailing parity byte.
- Returns `parity_done` and `low_pkt_valid` to `router_fsm`, closing the FSM↔datapath loop.

## Interface
Parameters:
- `DATA_W`, 8, byte width. Header layout: `[DATA_W-1:2]` payload length, `[1:0]` destination address.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pkt_valid`  in  1  source asserts while header/payload bytes are valid; deasserts on the parity byte.
- `data_in`  in  DATA_W  incoming byte.
- `fifo_full`  in  1  full flag of the currently addressed FIFO.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`  in  1 each  FSM state strobes.
- `dout`  out  DATA_W  byte presented to the FIFO.
- `parity_done`  out  1  parity byte captured.
- `low_pkt_valid`  out  1  `pkt_valid` fell while in the load state.
- `err`  out  1  packet error (parity mismatch; length mismatch when enabled).

## Operation
- Reset (`rst`=0): `dout`, `parity_done`, `low_pkt_valid` and `err` all clear to 0. Internal `header_byte`, `full_byte`, `int_parity` and `pkt_parity` also clear to 0.
- Header capture: when `detect_add & pkt_valid & data_in[1:0]!=2'b11`, load `header_byte<=data_in`. Address 2'b11 is ignored, so the previous value holds.
- `dout` priority, highest first:
  - `lfd_state`: `dout<=header_byte`.
  - `ld_state & ~fifo_full`: `dout<=data_in`.
  - `ld_state & fifo_full`: `full_byte<=data_in`; `dout` holds.
  - `laf_state`: `dout<=full_byte`.
  - Otherwise `dout` holds.
- `int_parity`:
  - Cleared on `detect_add`.
  - `lfd_state`: `^=header_byte`.
  - `ld_state & pkt_valid & ~full_state`: `^=data_in`.
- `low_pkt_valid`:
  - Set on `ld_state & ~pkt_valid`.
  - Cleared on `rst_int_reg`; the clear wins if both occur in the same cycle.
- `parity_done`:
  - Set on `(ld_state & ~fifo_full & ~pkt_valid) | (laf_state & low_pkt_valid & ~parity_done)`.
  - Cleared on `detect_add`; `detect_add` has priority.
- `pkt_parity`: loads `data_in` when `ld_state & ~fifo_full & ~pkt_valid`. In the `laf_state` completion case it loads `full_byte`.
- `err`: registered `int_parity != pkt_parity`, evaluated in the cycle after `parity_done` rises. Held until `detect_add`.

## Timing
- All register updates occur on the `clk` rising edge. `rst` acts immediately, regardless of clock.
- Latency: `dout` reflects `data_in` one cycle after `ld_state`.
- A buffered byte reaches `dout` one cycle after `laf_state`.
- `parity_done` rises one cycle after the qualifying condition. `err` is valid one cycle after `parity_done`.
- Simultaneous `detect_add` and an `ld_state` term cannot occur (the FSM is one-hot). If both are asserted, `detect_add` clears win and the `ld_state` actions still apply.
- Reset mid-packet: all outputs drop to 0 asynchronously. The next packet starts clean from `detect_add`.

## Configuration
- `ROUTER_REG_LEN_CHECK_EN` defined:
  - Adds a `DATA_W-2`-bit payload counter. It clears on `detect_add` and increments on each `ld_state & pkt_valid & ~full_state`.
  - `err` becomes `(parity mismatch) | (count != header_byte[DATA_W-1:2])`.
- Undefined: no counter is built, and `err` reflects parity only.

## Structure
- Shared package `router_pkg` holds the following, all used by `router_fsm`, `router_reg` and the FIFO:
  - `DATA_W`.
  - `ADDR_INVALID=2'b11`.
  - Header field positions `HDR_LEN_MSB/LSB` and `HDR_ADDR_MSB/LSB`.
- One sub-module, `router_parity_acc`, contains the `int_parity`/`pkt_parity` registers and the compare. It takes clear, header/data enables and returns the mismatch flag.

## Test plan
- Header 8'h0C (len 3, addr 0), payload 8'h11/22/33, parity 8'h0C, `fifo_full`=0: `dout` sequence is 0C,11,22,33; `parity_done`=1; `err`=0.
- Same packet with parity 8'h00: `err`=1 one cycle after `parity_done`. `err` clears on the next `detect_add`.
- `ld_state` with `fifo_full`=1 and `data_in`=8'h55, then `laf_state`: `dout` holds, then becomes 8'h55.
- `detect_add` with `data_in`=8'h0F (addr 3): `header_byte` unchanged, and the next `lfd_state` drives the prior header.
- `rst`=0 asserted mid-`ld_state`: all outputs 0 immediately. `rst_int_reg` pulse while `low_pkt_valid`=1: `low_pkt_valid`=0 next edge.
- Header 8'h0C with 2 payloads and correct parity: `err`=1 with `ROUTER_REG_LEN_CHECK_EN`, 0 without.
